// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store stage between execute and writeback. Accepts one memory
//   request per handshake, drives a synchronous BRAM with READ_LATENCY
//   cycles of read latency, returns sign/zero-extended load data and
//   registers the next-PC decision of the accepted instruction.
//
// Parameters
//   INST_SIZE     width of pc / bpc / npc (<= 32)
//   ADDR_BITS     BRAM word-address width (<= 29)
//   READ_LATENCY  BRAM read latency in cycles, 1..4
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   rea, wea                   load / store request (both set = store)
//   size, unsigned_ld          00 byte, 01 half, 1x word; zero-extend loads
//   addr, wdata                byte address, right-aligned store data
//   cond, pc, bpc              branch condition / jr target, pc, target
//   branch, jump, is_jr        next-PC controls
//   rsp_valid, rdata, misalign one-cycle response, load data, misalign flag
//   npc                        registered next pc
//   bram_en/we/addr/din/dout   BRAM interface
//
// Build option
//   MEM_ACCESS_MISALIGN_TRAP_EN  misaligned requests skip the BRAM and
//   respond with misalign=1; otherwise low address bits are force-aligned.

module mem_access_unit #(
  parameter int unsigned INST_SIZE    = 10,
  parameter int unsigned ADDR_BITS    = 18,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 rea,
  input  logic                 wea,
  input  logic [1:0]           size,
  input  logic                 unsigned_ld,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [31:0]          cond,
  input  logic [INST_SIZE-1:0] pc,
  input  logic [INST_SIZE-1:0] bpc,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 is_jr,
  output logic                 rsp_valid,
  output logic [31:0]          rdata,
  output logic                 misalign,
  output logic [INST_SIZE-1:0] npc,
  output logic                 bram_en,
  output logic [3:0]           bram_we,
  output logic [ADDR_BITS-1:0] bram_addr,
  output logic [31:0]          bram_din,
  input  logic [31:0]          bram_dout
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [INST_SIZE-1:0] npc_q, npc_d;

  logic                 is_load;
  logic                 trap_req;
  logic [1:0]           off_req;
  logic [3:0]           lane_mask;
  logic [INST_SIZE-1:0] npc_sel;
  logic [31:0]          lane_shift;
  logic [31:0]          ld_ext;
  logic                 load_rsp;

  // Addresses beyond the BRAM simply alias onto it.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_BITS+2];

  assign is_load   = rea && !wea;
  assign bram_addr = addr[ADDR_BITS+1:2];

  // Offset is force-aligned to the access size; for a legal access this
  // is identical to addr[1:0].
  always_comb begin
    off_req   = 2'b00;
    lane_mask = 4'b1111;
    bram_din  = wdata;
    case (size)
      2'b00: begin
        off_req   = addr[1:0];
        lane_mask = 4'b0001 << addr[1:0];
        bram_din  = {4{wdata[7:0]}};
      end
      2'b01: begin
        off_req   = {addr[1], 1'b0};
        lane_mask = 4'b0011 << {addr[1], 1'b0};
        bram_din  = {2{wdata[15:0]}};
      end
      default: begin
        off_req   = 2'b00;
        lane_mask = 4'b1111;
        bram_din  = wdata;
      end
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misaligned_req;

  assign misaligned_req = ((size == 2'b01) && addr[0]) ||
                          (size[1] && (addr[1:0] != 2'b00));
  // A request with neither rea nor wea touches no memory, so it cannot trap.
  assign trap_req = misaligned_req && (rea || wea);
  assign misalign = load_rsp ? 1'b0 : misalign_q;
`else
  assign trap_req = 1'b0;
  assign misalign = 1'b0;
`endif

  always_comb begin
    if (is_jr) begin
      npc_sel = cond[INST_SIZE-1:0];
    end else if (jump) begin
      npc_sel = bpc;
    end else if (branch && (cond == 32'd1)) begin
      npc_sel = bpc;
    end else begin
      npc_sel = pc + INST_SIZE'(4);
    end
  end

  always_comb begin
    lane_shift = bram_dout >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, lane_shift[7:0]}
                              : {{24{lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, lane_shift[15:0]}
                              : {{16{lane_shift[15]}}, lane_shift[15:0]};
      default: ld_ext = bram_dout;
    endcase
  end

  // Loads respond from the final WAIT cycle, where bram_dout has just become
  // valid; rdata is muxed straight from the lane extractor in that cycle and
  // the value is captured in rdata_q so it holds afterwards.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rdata_d   = rdata_q;
    npc_d     = npc_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    load_rsp  = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 4'b0000;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          npc_d  = npc_sel;
          off_d  = off_req;
          size_d = size;
          uns_d  = unsigned_ld;
          if (trap_req) begin
            state_d = S_RESP;
            rdata_d = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end else if (is_load) begin
            bram_en = 1'b1;
            state_d = S_WAIT;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end else begin
            bram_en = wea;
            bram_we = wea ? lane_mask : 4'b0000;
            state_d = S_RESP;
            rdata_d = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            misalign_d = 1'b0;
`endif
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid = 1'b1;
          load_rsp  = 1'b1;
          rdata_d   = ld_ext;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
`endif
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rdata = load_rsp ? ld_ext : rdata_q;
  assign npc   = npc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      npc_q   <= npc_d;
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        req_valid, rea, wea, unsigned_ld, branch, jump, is_jr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, cond;
  logic [9:0]  pc, bpc;

  logic        rdy2, rsp2, mis2, en2;
  logic [31:0] rd2, din2, dout2;
  logic [9:0]  npc2;
  logic [3:0]  we2;
  logic [17:0] ba2;

  logic        rdy3, rsp3, mis3, en3;
  logic [31:0] rd3, din3, dout3;
  logic [9:0]  npc3;
  logic [3:0]  we3;
  logic [17:0] ba3;

  mem_access_unit #(.INST_SIZE(10), .ADDR_BITS(18), .READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy2),
    .rea(rea), .wea(wea), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .cond(cond), .pc(pc), .bpc(bpc),
    .branch(branch), .jump(jump), .is_jr(is_jr),
    .rsp_valid(rsp2), .rdata(rd2), .misalign(mis2), .npc(npc2),
    .bram_en(en2), .bram_we(we2), .bram_addr(ba2), .bram_din(din2),
    .bram_dout(dout2)
  );

  mem_access_unit #(.INST_SIZE(10), .ADDR_BITS(18), .READ_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy3),
    .rea(rea), .wea(wea), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .cond(cond), .pc(pc), .bpc(bpc),
    .branch(branch), .jump(jump), .is_jr(is_jr),
    .rsp_valid(rsp3), .rdata(rd3), .misalign(mis3), .npc(npc3),
    .bram_en(en3), .bram_we(we3), .bram_addr(ba3), .bram_din(din3),
    .bram_dout(dout3)
  );

  // BRAM models: read-before-write, output delayed by the read latency.
  logic [31:0] mem2 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p2_1, p2_2, p3_1, p3_2, p3_3;

  always @(posedge clk) begin
    if (en2) begin
      for (int i = 0; i < 4; i++) begin
        if (we2[i]) mem2[ba2[7:0]][8*i +: 8] <= din2[8*i +: 8];
      end
    end
    p2_1 <= mem2[ba2[7:0]];
    p2_2 <= p2_1;
  end
  assign dout2 = p2_2;

  always @(posedge clk) begin
    if (en3) begin
      for (int j = 0; j < 4; j++) begin
        if (we3[j]) mem3[ba3[7:0]][8*j +: 8] <= din3[8*j +: 8];
      end
    end
    p3_1 <= mem3[ba3[7:0]];
    p3_2 <= p3_1;
    p3_3 <= p3_2;
  end
  assign dout3 = p3_3;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Values captured in the accept cycle and at the response.
  logic        acc_rdy2, acc_rdy3, acc_en2, acc_en3;
  logic [3:0]  acc_we2;
  logic [31:0] acc_din2;
  logic [17:0] acc_ba2;
  int          lat2, lat3;
  logic [31:0] r2, r3;
  logic        m2, m3;

  task automatic req(input logic r, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    rea = r; wea = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
    req_valid = 1'b1;
    #1;
    acc_rdy2 = rdy2; acc_rdy3 = rdy3;
    acc_en2  = en2;  acc_en3  = en3;
    acc_we2  = we2;  acc_din2 = din2; acc_ba2 = ba2;
    @(posedge clk); #1;
    req_valid = 1'b0; rea = 1'b0; wea = 1'b0;
    lat2 = 0; lat3 = 0; r2 = '0; r3 = '0; m2 = 1'b0; m3 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (rsp2 && lat2 == 0) begin lat2 = k; r2 = rd2; m2 = mis2; end
      if (rsp3 && lat3 == 0) begin lat3 = k; r3 = rd3; m3 = mis3; end
      if (lat2 != 0 && lat3 != 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int seen;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; rea = 1'b0; wea = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = '0; wdata = '0; cond = '0; pc = '0; bpc = '0;
    branch = 1'b0; jump = 1'b0; is_jr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  rdy2, 1);
    check("rst_rsp",    rsp2, 0);
    check("rst_rdata",  rd2,  0);
    check("rst_mis",    mis2, 0);
    check("rst_npc",    npc2, 0);
    check("rst_en",     en2,  0);
    check("rst_we",     we2,  0);
    check("rst_ready3", rdy3, 1);
    @(negedge clk);
    rstn = 1'b1;

    // Word store then word load
    pc = 10'h100;
    req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    check("stw_ready", acc_rdy2, 1);
    check("stw_en",    acc_en2,  1);
    check("stw_we",    acc_we2,  4'hF);
    check("stw_din",   acc_din2, 32'hDEADBEEF);
    check("stw_baddr", acc_ba2,  32'h4);
    check("stw_lat2",  lat2, 1);
    check("stw_lat3",  lat3, 1);
    check("stw_rdata", r2,   0);
    check("stw_npc",   npc2, 10'h104);

    req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    check("ldw_en",    acc_en2, 1);
    check("ldw_we",    acc_we2, 0);
    check("ldw_lat2",  lat2, 2);
    check("ldw_lat3",  lat3, 3);
    check("ldw_rd2",   r2, 32'hDEADBEEF);
    check("ldw_rd3",   r3, 32'hDEADBEEF);
    check("ldw_rsp_low", rsp2, 0);
    check("ldw_hold",  rd2, 32'hDEADBEEF);

    // Byte store into lane 3, signed and unsigned byte loads
    req(0, 1, 2'b00, 0, 32'h13, 32'h00000080);
    check("stb_we",    acc_we2,  4'b1000);
    check("stb_din",   acc_din2, 32'h80808080);
    req(1, 0, 2'b00, 0, 32'h13, 32'h0);
    check("ldb_s2",    r2, 32'hFFFFFF80);
    check("ldb_s3",    r3, 32'hFFFFFF80);
    req(1, 0, 2'b00, 1, 32'h13, 32'h0);
    check("ldb_u2",    r2, 32'h00000080);

    // Half loads over 0x8001_1234
    req(0, 1, 2'b10, 0, 32'h10, 32'h80011234);
    req(1, 0, 2'b01, 0, 32'h12, 32'h0);
    check("ldh_s_hi",  r2, 32'hFFFF8001);
    req(1, 0, 2'b01, 1, 32'h12, 32'h0);
    check("ldh_u_hi",  r3, 32'h00008001);
    req(1, 0, 2'b01, 0, 32'h10, 32'h0);
    check("ldh_s_lo",  r2, 32'h00001234);

    // Next-PC selection via no-op requests
    pc = 10'h3FC; bpc = 10'h020; branch = 1'b1; cond = 32'd1;
    req(0, 0, 2'b10, 0, 32'h0, 32'h0);
    check("npc_br_taken", npc2, 10'h020);
    check("nop_lat",      lat2, 1);
    check("nop_rdata",    r2,   0);
    cond = 32'd2;
    req(0, 0, 2'b10, 0, 32'h0, 32'h0);
    check("npc_br_wrap",  npc3, 10'h000);
    branch = 1'b0; is_jr = 1'b1; cond = 32'h154;
    req(0, 0, 2'b10, 0, 32'h0, 32'h0);
    check("npc_jr",       npc2, 10'h154);
    is_jr = 1'b0; jump = 1'b1; pc = 10'h040;
    req(0, 0, 2'b10, 0, 32'h0, 32'h0);
    check("npc_jump",     npc2, 10'h020);
    jump = 1'b0; cond = 32'h0;
    req(0, 0, 2'b10, 0, 32'h0, 32'h0);
    check("npc_seq",      npc2, 10'h044);

    // Misaligned accesses
    req(0, 1, 2'b10, 0, 32'h4, 32'h11223344);
    req(1, 0, 2'b10, 0, 32'h6, 32'h0);
    check("misw_en",    acc_en2, TRAP ? 0 : 1);
    check("misw_baddr", acc_ba2, 32'h1);
    check("misw_lat2",  lat2, TRAP ? 1 : 2);
    check("misw_lat3",  lat3, TRAP ? 1 : 3);
    check("misw_rdata", r2,   TRAP ? 32'h0 : 32'h11223344);
    check("misw_flag",  m2,   TRAP ? 1 : 0);
    req(0, 1, 2'b01, 0, 32'h13, 32'h0000ABCD);
    check("mish_we",    acc_we2, TRAP ? 4'b0000 : 4'b1100);
    check("mish_flag",  m3,      TRAP ? 1 : 0);
    req(1, 0, 2'b10, 0, 32'h10, 32'h0);
    check("mish_mem",   r3,  TRAP ? 32'h80011234 : 32'hABCD1234);
    check("mish_clear", m2,  0);

    // Reset while both units are in WAIT
    @(negedge clk);
    rea = 1'b1; wea = 1'b0; size = 2'b10; addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rea = 1'b0;
    rstn = 1'b0;
    #1;
    check("rstw_rsp",   rsp3, 0);
    check("rstw_ready", rdy3, 1);
    check("rstw_rdata", rd3,  0);
    check("rstw_npc",   npc3, 0);
    check("rstw_rd2",   rd2,  0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp2 || rsp3) seen++;
    end
    check("rstw_no_rsp", seen, 0);
    check("rstw_ready_after", rdy3, 1);
    check("rstw_mis",    mis3, 0);
    check("rstw_en",     en3,  0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store stage between execute and writeback of the CPU core.
- Accepts one memory request per handshake and drives an external synchronous BRAM with a configurable read latency.
- Supports byte, half and word accesses with byte-enable stores and sign/zero-extended loads.
- Registers the next-PC decision for the accepted instruction.

Parameters:
- INST_SIZE, 10, width of pc/bpc/npc.
- ADDR_BITS, 18, BRAM word-address width; BRAM holds 2^ADDR_BITS 32-bit words.
- READ_LATENCY, 1, BRAM cycles from bram_en to valid bram_dout; legal range 1..4.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- rea  in  1  load request.
- wea  in  1  store request; rea=wea=1 is treated as a store.
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- unsigned_ld  in  1  zero-extend sub-word load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- cond  in  32  branch condition value / jr target.
- pc  in  INST_SIZE  current pc.
- bpc  in  INST_SIZE  branch/jump target.
- branch  in  1  conditional branch.
- jump  in  1  unconditional jump.
- is_jr  in  1  register jump.
- rsp_valid  out  1  one-cycle response pulse.
- rdata  out  32  load result, extended.
- misalign  out  1  response flags a misaligned access.
- npc  out  INST_SIZE  registered next pc.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables; bit i maps to byte lane [8i+7:8i].
- bram_addr  out  ADDR_BITS  BRAM word address, equal to addr[ADDR_BITS+1:2].
- bram_din  out  32  lane-shifted store data.
- bram_dout  in  32  BRAM read data.

Behaviour:
- Reset (async, rstn=0): state IDLE, req_ready=1, rsp_valid=0, rdata=0, misalign=0, npc=0, bram_en=0, bram_we=0, latency counter=0.
- Accept condition: req_valid && req_ready. req_ready=1 only in IDLE.
- A request with rea=wea=0 still registers npc and produces rsp_valid the next cycle with rdata=0.
- npc is captured at accept and held until the next accept. Priority:
  - is_jr: cond[INST_SIZE-1:0]
  - else jump: bpc
  - else branch && cond==1: bpc
  - else pc+4, truncated to INST_SIZE (wraps).
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=0.
- Store, in the accept cycle (combinational from request):
  - bram_en=1; bram_we = lane mask shifted by addr[1:0]: byte 0001<<a, half 0011<<a, word 1111.
  - bram_din = wdata replicated into lanes.
  - Next cycle: state RESP, rsp_valid=1.
- Load:
  - Accept cycle: bram_en=1, bram_we=0. State WAIT, counter loaded with READ_LATENCY-1.
  - WAIT decrements the counter. When it reaches 0 the unit samples bram_dout, selects the lane by the captured addr[1:0] and size, and extends it (sign unless unsigned_ld).
  - rsp_valid rises exactly READ_LATENCY cycles after accept.
- RESP: rsp_valid=1 for one cycle, then IDLE. req_ready returns to 1 in the cycle after rsp_valid. A request may not be accepted in the rsp_valid cycle.
- Between responses: rdata and misalign hold their last values; rsp_valid=0.
- Reset mid-WAIT: the in-flight request is dropped and no rsp_valid is produced.
- Addresses above BRAM range: upper bits are ignored (alias/wrap).

Optional Feature:
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - A misaligned request drives no BRAM access (bram_en=0, bram_we=0).
  - Response follows next cycle with misalign=1, rdata=0.
  - npc is still captured.
- Undefined:
  - misalign is tied 0.
  - Low address bits are force-aligned: half uses addr[1] only, word ignores addr[1:0].
  - Access proceeds normally.

Test Plan:
- Store word wdata=0xDEADBEEF at addr=0x10, then load word with READ_LATENCY=2 -> bram_we=1111 on store; rsp_valid 2 cycles after load accept; rdata=0xDEADBEEF.
- Store byte 0x80 at addr=0x13, then load byte signed and unsigned -> bram_we=1000, bram_din[31:24]=0x80; rdata=0xFFFFFF80, then 0x00000080.
- Load half at addr=0x12 over word 0x8001_1234 -> signed 0xFFFF8001, unsigned 0x00008001.
- npc checks with pc=0x3FC, bpc=0x020:
  - branch=1, cond=1 -> npc=0x020.
  - branch=1, cond=2 -> npc=0x000 (wrap).
  - is_jr=1, cond=0x154 -> npc=0x154.
- Load word at addr=0x6 with macro defined -> misalign=1, rdata=0, bram_en never asserted. Macro undefined -> reads word 1.
- Assert rstn=0 during WAIT with READ_LATENCY=3 -> no rsp_valid; req_ready=1 after release; all outputs at reset values.
